// File: rtl/spw_pkg.sv
// Shared types and constants for the SpaceWire link-interface state machine.
package spw_pkg;

  typedef enum logic [2:0] {
    ERROR_RESET = 3'd0,
    ERROR_WAIT  = 3'd1,
    READY       = 3'd2,
    STARTED     = 3'd3,
    CONNECTING  = 3'd4,
    RUN         = 3'd5
  } state_t;

  localparam int unsigned ERR_DISC = 0;
  localparam int unsigned ERR_PAR  = 1;
  localparam int unsigned ERR_ESC  = 2;

  localparam int unsigned T_6U4_DEF  = 640;
  localparam int unsigned T_12U8_DEF = 1280;
  localparam int unsigned TMR_W_DEF  = 12;

  typedef struct packed {
    logic rx_en;
    logic tx_en;
    logic fct_allow;
    logic data_allow;
    logic running;
  } link_out_t;

  function automatic link_out_t state_outputs(state_t s);
    link_out_t o;
    o = '0;
    case (s)
      ERROR_WAIT, READY: o.rx_en = 1'b1;
      STARTED: begin
        o.rx_en = 1'b1;
        o.tx_en = 1'b1;
      end
      CONNECTING: begin
        o.rx_en     = 1'b1;
        o.tx_en     = 1'b1;
        o.fct_allow = 1'b1;
      end
      RUN: begin
        o.rx_en      = 1'b1;
        o.tx_en      = 1'b1;
        o.fct_allow  = 1'b1;
        o.data_allow = 1'b1;
        o.running    = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/spw_link_ctrl_if.sv
// Bundle of receiver events, host commands and link status for one SpaceWire port.
interface spw_link_ctrl_if;
  logic       link_start;
  logic       auto_start;
  logic       link_disable;
  logic       rx_got_null;
  logic       rx_got_fct;
  logic       rx_got_nchar;
  logic       rx_got_time;
  logic       rx_err_disc;
  logic       rx_err_par;
  logic       rx_err_esc;
  logic       credit_err;
  logic       rx_enable;
  logic       tx_enable;
  logic       tx_fct_allow;
  logic       tx_data_allow;
  logic       link_running;
  logic [2:0] state;
  logic [2:0] err_last;

  modport master (
    output link_start, auto_start, link_disable,
           rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time,
           rx_err_disc, rx_err_par, rx_err_esc, credit_err,
    input  rx_enable, tx_enable, tx_fct_allow, tx_data_allow,
           link_running, state, err_last
  );

  modport slave (
    input  link_start, auto_start, link_disable,
           rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time,
           rx_err_disc, rx_err_par, rx_err_esc, credit_err,
    output rx_enable, tx_enable, tx_fct_allow, tx_data_allow,
           link_running, state, err_last
  );
endinterface

// File: rtl/spw_link_timer.sv
// State dwell timer: cleared on state entry, counts up, saturates at T_12U8.
module spw_link_timer #(
  parameter int unsigned T_6U4  = 640,
  parameter int unsigned T_12U8 = 1280,
  parameter int unsigned TMR_W  = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_at_6u4,
  output logic o_at_12u8
);

  localparam logic [TMR_W-1:0] C_6U4_M1  = TMR_W'(T_6U4 - 1);
  localparam logic [TMR_W-1:0] C_12U8_M1 = TMR_W'(T_12U8 - 1);
  localparam logic [TMR_W-1:0] C_SAT     = TMR_W'(T_12U8);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != C_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_6u4  = (r_cnt == C_6U4_M1);
  assign o_at_12u8 = (r_cnt == C_12U8_M1);

endmodule

// File: rtl/spw_link_ctrl.sv
// SpaceWire exchange-level link-interface FSM (ErrorReset..Run).
// Optional SPW_ERR_CNT_EN adds a saturating err_count output.
module spw_link_ctrl
  import spw_pkg::*;
#(
  parameter int unsigned T_6U4  = T_6U4_DEF,
  parameter int unsigned T_12U8 = T_12U8_DEF,
  parameter int unsigned TMR_W  = TMR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  spw_link_ctrl_if.slave   bus
`ifdef SPW_ERR_CNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  state_t    r_state;
  state_t    w_state_nxt;
  link_out_t r_out;
  logic      r_got_null;
  logic [2:0] r_err_last;

  logic w_at_6u4;
  logic w_at_12u8;
  logic w_clr;
  logic w_err;
  logic w_rx_evt;
  logic w_link_en;
  logic w_null_seen;
  logic w_err_trans;
  logic [2:0] w_err_bits;

  spw_link_timer #(
    .T_6U4  (T_6U4),
    .T_12U8 (T_12U8),
    .TMR_W  (TMR_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .o_at_6u4  (w_at_6u4),
    .o_at_12u8 (w_at_12u8)
  );

  // Disconnect only counts once the link has seen a NULL.
  always_comb begin
    w_err_bits           = '0;
    w_err_bits[ERR_DISC] = bus.rx_err_disc & r_got_null;
    w_err_bits[ERR_PAR]  = bus.rx_err_par;
    w_err_bits[ERR_ESC]  = bus.rx_err_esc;
    w_err       = |w_err_bits;
    w_rx_evt    = bus.rx_got_fct | bus.rx_got_nchar | bus.rx_got_time;
    w_link_en   = !bus.link_disable &&
                  (bus.link_start || (bus.auto_start && r_got_null));
    w_null_seen = r_got_null | bus.rx_got_null;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_trans = 1'b0;
    case (r_state)
      ERROR_RESET: begin
        if (w_at_6u4) w_state_nxt = ERROR_WAIT;
      end
      ERROR_WAIT: begin
        if (w_err) begin
          w_state_nxt = ERROR_RESET;
          w_err_trans = 1'b1;
        end else if (w_rx_evt) w_state_nxt = ERROR_RESET;
        else if (w_at_12u8)     w_state_nxt = READY;
      end
      READY: begin
        if (w_err) begin
          w_state_nxt = ERROR_RESET;
          w_err_trans = 1'b1;
        end else if (w_rx_evt) w_state_nxt = ERROR_RESET;
        else if (w_link_en)     w_state_nxt = STARTED;
      end
      STARTED: begin
        if (w_err) begin
          w_state_nxt = ERROR_RESET;
          w_err_trans = 1'b1;
        end else if (w_rx_evt || bus.link_disable) w_state_nxt = ERROR_RESET;
        else if (w_at_12u8)   w_state_nxt = ERROR_RESET;
        else if (w_null_seen) w_state_nxt = CONNECTING;
      end
      CONNECTING: begin
        if (w_err) begin
          w_state_nxt = ERROR_RESET;
          w_err_trans = 1'b1;
        end else if (bus.rx_got_nchar || bus.rx_got_time || bus.link_disable)
          w_state_nxt = ERROR_RESET;
        else if (w_at_12u8)      w_state_nxt = ERROR_RESET;
        else if (bus.rx_got_fct) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_err || bus.credit_err) begin
          w_state_nxt = ERROR_RESET;
          w_err_trans = 1'b1;
        end else if (!w_link_en) w_state_nxt = ERROR_RESET;
      end
      default: w_state_nxt = ERROR_RESET;
    endcase
  end

  assign w_clr = (w_state_nxt != r_state);

  // Outputs are decoded from the next state so they stay aligned with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ERROR_RESET;
      r_out      <= '0;
      r_err_last <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= state_outputs(w_state_nxt);
      if (w_err_trans) begin
        r_err_last <= (r_state == RUN && bus.credit_err) ? 3'b111 : w_err_bits;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == ERROR_RESET) begin
      r_got_null <= 1'b0;
    end else if (bus.rx_got_null && r_out.rx_en) begin
      r_got_null <= 1'b1;
    end
  end

`ifdef SPW_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_trans && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_count = r_err_cnt;
`endif

  assign bus.rx_enable     = r_out.rx_en;
  assign bus.tx_enable     = r_out.tx_en;
  assign bus.tx_fct_allow  = r_out.fct_allow;
  assign bus.tx_data_allow = r_out.data_allow;
  assign bus.link_running  = r_out.running;
  assign bus.state         = r_state;
  assign bus.err_last      = r_err_last;

endmodule

// File: doc/spw_link_ctrl.md
Name: spw_link_ctrl

Overview:
SpaceWire link-interface state machine (ECSS-E-ST-50-12C exchange-level initialisation). It sequences the port receiver and transmitter through ErrorReset, ErrorWait, Ready, Started, Connecting and Run. It consumes decoded receiver events and driver commands, and produces receiver/transmitter enables, transmit mode and link status. It sits between the host register interface and the port rx/tx pair, one instance per port.

Parameters:
T_6U4, 640, clk cycles for the 6.4 us ErrorReset dwell (640 cycles at 100 MHz)
T_12U8, 1280, clk cycles for the 12.8 us ErrorWait dwell and the Started/Connecting timeouts
TMR_W, 12, timer counter width; must hold T_12U8

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous reset, active-high
link_start  in  1  level: request link start
auto_start  in  1  level: start on first received NULL
link_disable  in  1  level: force link down
rx_got_null  in  1  pulse: receiver decoded a NULL
rx_got_fct  in  1  pulse: receiver decoded an FCT
rx_got_nchar  in  1  pulse: receiver decoded an N-Char
rx_got_time  in  1  pulse: receiver decoded a time-code
rx_err_disc  in  1  pulse: disconnect (no strobe/data edge timeout)
rx_err_par  in  1  pulse: parity error
rx_err_esc  in  1  pulse: escape-sequence error
credit_err  in  1  pulse: credit overflow from flow control
rx_enable  out  1  receiver run enable (0 holds rx in reset)
tx_enable  out  1  transmitter run enable
tx_fct_allow  out  1  transmitter may send FCTs
tx_data_allow  out  1  transmitter may send N-Chars/time-codes
link_running  out  1  state == Run
state  out  3  current state encoding (from package)
err_last  out  3  one-hot {esc, par, disc} for the last error-induced reset; credit errors also flagged here as disc=par=esc=1

Behaviour:
- Reset: state=ErrorReset, timer=0, got_null flag=0, err_last=0. All enables=0 and link_running=0. Outputs registered; state changes one cycle after the triggering input.
- got_null: sticky flag, set by rx_got_null while rx_enable=1. Cleared in ErrorReset.
- link_en = !link_disable && (link_start || (auto_start && got_null)).
- err = rx_err_disc | rx_err_par | rx_err_esc. Disconnect is honoured only once got_null=1, per standard; before that, disc is ignored.
- Timer: cleared on every state entry, increments each cycle, saturates at T_12U8.
- ErrorReset: all enables 0. timer==T_6U4-1 -> ErrorWait.
- ErrorWait: rx_enable=1. Any err, rx_got_fct, rx_got_nchar or rx_got_time -> ErrorReset. timer==T_12U8-1 -> Ready.
- Ready: rx_enable=1. Error rules as in ErrorWait -> ErrorReset. link_en -> Started.
- Started: rx+tx enabled, NULLs only. Error rules as in ErrorWait -> ErrorReset. link_disable -> ErrorReset. got_null (flag or same-cycle pulse) -> Connecting. timer==T_12U8-1 -> ErrorReset.
- Connecting: tx_fct_allow=1. err, nchar, time or link_disable -> ErrorReset. rx_got_fct -> Run. Timeout as in Started.
- Run: tx_fct_allow=1, tx_data_allow=1, link_running=1. err, credit_err or !link_en -> ErrorReset.
- Priority within one cycle: error/disable > timeout > forward progress. Example: rx_got_fct together with rx_err_par in Connecting -> ErrorReset.
- err_last: updated only on error-induced transitions into ErrorReset. Holds through timeouts and disable.
- rst asserted in any state -> ErrorReset next cycle, regardless of other inputs.
- Unused state encodings -> ErrorReset.

Optional Feature:
SPW_ERR_CNT_EN: adds output err_count[7:0]. The counter increments on each error-induced entry into ErrorReset, saturates at 255 and clears on rst. Without the macro, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package spw_pkg: state localparams (ERROR_RESET=0, ERROR_WAIT=1, READY=2, STARTED=3, CONNECTING=4, RUN=5), err_last bit indices, default timer constants.
- Sub-module spw_link_timer: clear/increment/saturate counter with two compare strobes, at_6u4 and at_12u8.

Test Plan:
- Reset then idle with T_6U4=8, T_12U8=16 -> ErrorWait at cycle 8, Ready 16 cycles later; all tx outputs stay 0.
- Ready, link_start=1, NULL pulse 5 cycles later, FCT 3 cycles after that -> Started, Connecting, Run in sequence; link_running=1, tx_data_allow=1.
- Started with no NULL for T_12U8 cycles -> ErrorReset; err_last unchanged.
- Run with rx_err_par pulse -> ErrorReset next cycle; err_last=3'b010; with SPW_ERR_CNT_EN, err_count increments 0->1.
- Ready, auto_start=1, link_start=0, NULL received -> Started; same with link_disable=1 -> remains Ready.
- Connecting with rx_got_fct and rx_err_esc in the same cycle -> ErrorReset, err_last=3'b100; rst mid-Run -> ErrorReset with all outputs 0.
